// File: rtl/ysyx_24070016_pkg.sv
// Shared types for the IF/ID boundary: buffer occupancy state and the fetch payload record.
package ysyx_24070016_pkg;

    localparam int unsigned IFID_PC_W   = 32;
    localparam int unsigned IFID_INST_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_e;

    typedef struct packed {
        logic [IFID_PC_W-1:0]   pc;
        logic [IFID_INST_W-1:0] inst;
        logic [IFID_PC_W-1:0]   dnpc;
    } ifid_payload_t;

endpackage

// File: rtl/ysyx_24070016_if_id_perf.sv
// Transfer and stall counters for the IF/ID buffer; only built with YSYX_IFID_PERF_EN.
module ysyx_24070016_if_id_perf
    import ysyx_24070016_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        xfer,
    input  logic        stall,
    output logic [31:0] perf_xfer_cnt,
    output logic [31:0] perf_stall_cnt
);

    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters wrap naturally; only reset clears them, flush does not.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q + {31'd0, xfer};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_xfer_cnt  = xfer_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/ysyx_24070016_if_id_buf.sv
// Two-entry skid buffer between IFU and IDU; ready is purely registered-state based.
// Optional performance counters are enabled with YSYX_IFID_PERF_EN.
module ysyx_24070016_if_id_buf
    import ysyx_24070016_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_dnpc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_dnpc,
    input  logic              flush
`ifdef YSYX_IFID_PERF_EN
    ,
    output logic [31:0]       perf_xfer_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // Same layout as ifid_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   dnpc;
    } payload_t;

    ifid_state_e state_q, state_d;
    payload_t    main_q, main_d;
    payload_t    skid_q, skid_d;
    payload_t    in_pl;
    logic        in_fire;
    logic        out_fire;

    assign in_pl     = '{pc: in_pc, inst: in_inst, dnpc: in_dnpc};
    assign in_ready  = !rst && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Redirect: anything held or arriving this cycle is wrong-path.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_pl;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_pl;
                    end else if (in_fire) begin
                        skid_d  = in_pl;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc   = main_q.pc;
    assign out_inst = main_q.inst;
    assign out_dnpc = main_q.dnpc;

`ifdef YSYX_IFID_PERF_EN
    ysyx_24070016_if_id_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .xfer           (out_fire),
        .stall          (out_valid && !out_ready),
        .perf_xfer_cnt  (perf_xfer_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_24070016_if_id_buf.sv
// Scoreboard bench for the IF/ID buffer: accepted payloads are queued and matched on delivery.
module tb_ysyx_24070016_if_id_buf;
    import ysyx_24070016_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_dnpc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_dnpc;
    logic        flush;
`ifdef YSYX_IFID_PERF_EN
    logic [31:0] perf_xfer_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            idx     = 0;
    bit            mon_en  = 1'b0;
    ifid_payload_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_24070016_if_id_buf dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_dnpc        (in_dnpc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_dnpc       (out_dnpc),
        .flush          (flush)
`ifdef YSYX_IFID_PERF_EN
        ,
        .perf_xfer_cnt  (perf_xfer_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Occupancy model is the scoreboard depth; delivery is compared against its head.
    always @(negedge clk) begin
        ifid_payload_t exp_pl;
        if (mon_en) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, (!rst && sb_q.size() < 2)});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_out", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_pl = sb_q.pop_front();
                    chk("out_pc", {32'd0, out_pc}, {32'd0, exp_pl.pc});
                    chk("out_inst", {32'd0, out_inst}, {32'd0, exp_pl.inst});
                    chk("out_dnpc", {32'd0, out_dnpc}, {32'd0, exp_pl.dnpc});
                    $display("[TB] deliver pc=0x%08h inst=0x%08h dnpc=0x%08h", out_pc, out_inst, out_dnpc);
                end
            end
            if (rst || flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back('{pc: in_pc, inst: in_inst, dnpc: in_dnpc});
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = 32'h00000413 ^ {pc[7:0], 8'h00, pc[15:0]};
        in_dnpc   = pc + 32'd4;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Sequential PC stream; the PC only advances once the buffer has taken it.
    task automatic stream(input logic v, input logic ordy, input logic fl);
        logic [31:0] pc;
        pc = 32'h80000000 + 32'(idx) * 32'd4;
        if (v && in_ready)
            idx++;
        step(v, pc, ordy, fl);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idx = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        in_dnpc   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Single fetch with one cycle of latency.
        step(1'b1, 32'h80000000, 1'b1, 1'b0);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_out_pc", {32'd0, out_pc}, 64'h80000000);
        chk("t1_out_inst", {32'd0, out_inst}, 64'h00000413);
        chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Full-rate stream of eight.
        do_reset();
        repeat (8) stream(1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t2_drained", 64'(sb_q.size()), 64'd0);
`ifdef YSYX_IFID_PERF_EN
        chk("t2_perf_xfer", {32'd0, perf_xfer_cnt}, 64'd8);
`endif

        // Backpressure for three cycles fills the skid register.
        do_reset();
        repeat (4) stream(1'b1, 1'b0, 1'b0);
        chk("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
        chk("t3_out_pc_hold", {32'd0, out_pc}, 64'h80000000);
        chk("t3_stored", 64'(sb_q.size()), 64'd2);
`ifdef YSYX_IFID_PERF_EN
        chk("t3_perf_stall", {32'd0, perf_stall_cnt}, 64'd3);
`endif
        repeat (6) stream(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t3_drained", 64'(sb_q.size()), 64'd0);

        // Flush from FULL, then from ONE with an accepted input, then with a delivery.
        do_reset();
        repeat (2) stream(1'b1, 1'b0, 1'b0);
        chk("t4_in_ready_full", {63'd0, in_ready}, 64'd0);
        step(1'b1, 32'h80000100, 1'b0, 1'b1);
        chk("t4_flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_flush_in_ready", {63'd0, in_ready}, 64'd1);
        step(1'b1, 32'h80000200, 1'b0, 1'b0);
        step(1'b1, 32'h80000100, 1'b0, 1'b1);
        chk("t4_drop_out_valid", {63'd0, out_valid}, 64'd0);
        step(1'b1, 32'h80000300, 1'b1, 1'b0);
        step(1'b1, 32'h80000100, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes.
        do_reset();
        for (int i = 0; i < 60; i++)
            stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("rand_drained", 64'(sb_q.size()), 64'd0);

        // Reset while FULL.
        do_reset();
        repeat (2) stream(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_out_pc", {32'd0, out_pc}, 64'd0);
`ifdef YSYX_IFID_PERF_EN
        chk("t5_perf_xfer", {32'd0, perf_xfer_cnt}, 64'd0);
        chk("t5_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        rst = 1'b0;
        idx = 0;
        step(1'b1, 32'h80000000, 1'b0, 1'b0);
        chk("t5_out_valid_after", {63'd0, out_valid}, 64'd1);
        chk("t5_out_pc_after", {32'd0, out_pc}, 64'h80000000);
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t5_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_if_id_buf.md
# ysyx_24070016_if_id_buf

Two-entry elastic pipeline buffer between the instruction fetch unit and the instruction decode unit. It carries the fetched PC, instruction word and simulator next-PC, and decouples the two stages with valid/ready handshakes. It breaks every combinational path between the stages, including ready, while sustaining one transfer per cycle. A flush input discards buffered instructions on a control-flow redirect.

## Interface
- `PC_W`, default 32: PC and dnpc width.
- `INST_W`, default 32: instruction width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  IFU offers a payload.
- `in_ready`  out  1  buffer can accept a payload.
- `in_pc`  in  PC_W  fetched PC.
- `in_inst`  in  INST_W  fetched instruction.
- `in_dnpc`  in  PC_W  next PC computed by the IFU, for the simulator.
- `out_valid`  out  1  payload available to the IDU.
- `out_ready`  in  1  IDU accepts the payload.
- `out_pc`, `out_inst`, `out_dnpc`  out  PC_W/INST_W/PC_W  head payload.
- `flush`  in  1  discard all buffered and incoming payloads.
- `perf_xfer_cnt`, `perf_stall_cnt`  out  32 each  present only with `YSYX_IFID_PERF_EN`.

## Operation
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage is a main register (drives the out_* ports) and a skid register.
- State register takes the values EMPTY, ONE and FULL.
  - out_valid = (state != EMPTY).
  - in_ready = !rst & (state != FULL). It depends only on state and rst, never on out_ready.
- State transitions when flush = 0:
  - EMPTY: if in_fire, main ← in and go to ONE.
  - ONE, in_fire & out_fire: main ← in, stay in ONE.
  - ONE, in_fire & !out_fire: skid ← in, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main ← skid, go to ONE.
  - FULL, no out_fire: hold.
- Flush:
  - flush = 1 forces the next state to EMPTY from every state.
  - Flush has priority over in_fire and out_fire. An input accepted in the flush cycle is dropped.
  - out_fire in the flush cycle still counts as delivered to the IDU.
- Hold rule: while out_valid & !out_ready, out_* are stable.
- Payload registers load only as listed above. When out_valid = 0, out_* keep their last value.
- Ordering is strict FIFO. No payload is duplicated or lost except through flush.
- The IFU must hold in_* stable while in_valid & !in_ready. The buffer does not check this.

## Timing
- Reset values: state EMPTY, out_valid 0, in_ready 0 during rst, main and skid payloads 0, perf counters 0.
- Latency: a payload accepted in cycle N appears on out_* in cycle N+1.
- Throughput is 1 per cycle while out_ready = 1. A full-rate stream never reaches FULL.
- After one out_ready-low cycle under a full-rate stream, the buffer is FULL and in_ready = 0 in the next cycle.
- From FULL, the first out_fire reasserts in_ready in the following cycle.
- The first cycle after flush: out_valid = 0, in_ready = 1.
- rst asserted mid-stream: on the next edge the state matches the reset values above.

## Configuration
- `YSYX_IFID_PERF_EN` defined: two 32-bit counters, cleared by rst only (not by flush), wrapping modulo 2^32.
  - perf_xfer_cnt increments on out_fire.
  - perf_stall_cnt increments on cycles with out_valid & !out_ready.
- `YSYX_IFID_PERF_EN` undefined: the perf ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package `ysyx_24070016_pkg` holds:
  - the 2-bit state enum: EMPTY=0, ONE=1, FULL=2;
  - the payload struct {pc, inst, dnpc}.
- The counters live in sub-module `ysyx_24070016_if_id_perf`, instantiated only under the macro.
- All other logic is in this module.

## Test plan
- Reset, then in_valid=1 with pc 0x80000000, inst 0x00000413, out_ready=1 → out_valid=1 next cycle with the same pc/inst; in_ready never drops.
- 8-cycle stream with pc 0x80000000..0x8000001C and out_ready=1 → outputs in order, one per cycle, 1-cycle lag; perf_xfer_cnt=8.
- Stream with out_ready=0 for 3 cycles → state FULL, in_ready=0, out_pc holds 0x80000000, 2 payloads stored; on out_ready=1 all resume in order with no loss; perf_stall_cnt=3.
- FULL buffer, flush=1 with in_valid=1 (pc 0x80000100) → next cycle out_valid=0 and in_ready=1; pc 0x80000100 is never output.
- rst asserted in FULL → next cycle out_valid=0, out_pc=0, counters=0; after rst release the next input pc 0x80000000 appears 1 cycle later.
